// File: rtl/pe_datapath_v2.sv
// Processing-element datapath: ifmap/weight scratchpads, a 3-stage MAC pipeline
// with a saturating psum scratchpad, and a credit-gated output FIFO.
module pe_datapath_v2 #(
  parameter int DATA_BITWIDTH       = 8,
  parameter int PSUM_BITWIDTH       = 20,
  parameter int IFMAP_ADDR_BITWIDTH = 4,
  parameter int WGHT_ADDR_BITWIDTH  = 7,
  parameter int PSUM_ADDR_BITWIDTH  = 3,
  parameter int OUT_FIFO_DEPTH      = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_ifmap_we,
  input  logic [IFMAP_ADDR_BITWIDTH-1:0] i_ifmap_wa,
  input  logic [DATA_BITWIDTH-1:0]       i_ifmap_data,
  input  logic                           i_wght_we,
  input  logic [WGHT_ADDR_BITWIDTH-1:0]  i_wght_wa,
  input  logic [DATA_BITWIDTH-1:0]       i_wght_data,
  input  logic                           i_issue,
  output logic                           o_issue_ready,
  input  logic [1:0]                     i_op,
  input  logic                           i_out,
  input  logic [IFMAP_ADDR_BITWIDTH-1:0] i_ifmap_ra,
  input  logic [WGHT_ADDR_BITWIDTH-1:0]  i_wght_ra,
  input  logic [PSUM_ADDR_BITWIDTH-1:0]  i_psum_a,
  input  logic [PSUM_BITWIDTH-1:0]       i_psum_data,
  output logic [PSUM_BITWIDTH-1:0]       o_psum_data,
  output logic                           o_psum_valid,
  input  logic                           i_psum_ready,
  output logic                           o_sat,
  input  logic                           i_clr_sat
);

  localparam int DW    = DATA_BITWIDTH;
  localparam int PW    = PSUM_BITWIDTH;
  localparam int PTR_W = $clog2(OUT_FIFO_DEPTH);
  localparam int CNT_W = $clog2(OUT_FIFO_DEPTH) + 2;

  localparam logic signed [PW-1:0] PSUM_MAX = {1'b0, {(PW-1){1'b1}}};
  localparam logic signed [PW-1:0] PSUM_MIN = {1'b1, {(PW-1){1'b0}}};

  typedef enum logic [1:0] {
    OP_MAC  = 2'b00,
    OP_ACC  = 2'b01,
    OP_CLR  = 2'b10,
    OP_LOAD = 2'b11
  } op_t;

  logic signed [DW-1:0] r_ifmap_mem [2**IFMAP_ADDR_BITWIDTH];
  logic signed [DW-1:0] r_wght_mem  [2**WGHT_ADDR_BITWIDTH];
  logic signed [PW-1:0] r_psum_mem  [2**PSUM_ADDR_BITWIDTH];
  logic        [PW-1:0] r_fifo_mem  [OUT_FIFO_DEPTH];

  logic                          r_s1_valid, r_s2_valid, r_s3_valid;
  logic signed [DW-1:0]          r_s1_ifmap, r_s1_wght;
  logic signed [2*DW-1:0]        r_s2_prod, r_s3_prod;
  op_t                           r_s1_op, r_s2_op, r_s3_op;
  logic                          r_s1_out, r_s2_out, r_s3_out;
  logic [PSUM_ADDR_BITWIDTH-1:0] r_s1_a, r_s2_a, r_s3_a;
  logic signed [PW-1:0]          r_s1_data, r_s2_data, r_s3_data;

  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_sat;

  logic                 w_issue_fire, w_push, w_pop, w_ovf, w_sat_hit;
  logic signed [PW-1:0] w_psum_old, w_addend, w_result;
  logic signed [PW:0]   w_sum;
  logic [CNT_W-1:0]     w_inflight;

  // NOTE: scratchpad and pipeline payload registers carry no reset; only the
  // valid bits decide whether their contents are ever used.
  always_ff @(posedge i_clk) begin
    if (i_ifmap_we) r_ifmap_mem[i_ifmap_wa] <= i_ifmap_data;
    if (i_wght_we)  r_wght_mem[i_wght_wa]   <= i_wght_data;
  end

  assign w_issue_fire = i_issue & o_issue_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_s3_valid <= 1'b0;
    end else begin
      r_s1_valid <= w_issue_fire;
      r_s2_valid <= r_s1_valid;
      r_s3_valid <= r_s2_valid;
    end
  end

  // Reads register the pre-write spad contents, so a same-cycle write is seen next cycle.
  always_ff @(posedge i_clk) begin
    r_s1_ifmap <= r_ifmap_mem[i_ifmap_ra];
    r_s1_wght  <= r_wght_mem[i_wght_ra];
    r_s1_op    <= op_t'(i_op);
    r_s1_out   <= i_out;
    r_s1_a     <= i_psum_a;
    r_s1_data  <= i_psum_data;

    r_s2_prod  <= (2*DW)'(r_s1_ifmap) * (2*DW)'(r_s1_wght);
    r_s2_op    <= r_s1_op;
    r_s2_out   <= r_s1_out;
    r_s2_a     <= r_s1_a;
    r_s2_data  <= r_s1_data;

    r_s3_prod  <= r_s2_prod;
    r_s3_op    <= r_s2_op;
    r_s3_out   <= r_s2_out;
    r_s3_a     <= r_s2_a;
    r_s3_data  <= r_s2_data;
  end

  // The psum read is combinational, so the previous op's write is already visible here.
  assign w_psum_old = r_psum_mem[r_s3_a];
  assign w_addend   = (r_s3_op == OP_MAC) ? PW'(r_s3_prod) : r_s3_data;
  assign w_sum      = (PW+1)'(w_psum_old) + (PW+1)'(w_addend);
  assign w_ovf      = w_sum[PW] ^ w_sum[PW-1];

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_result  = '0;
    w_sat_hit = 1'b0;
    case (r_s3_op)
      OP_MAC, OP_ACC: begin
        w_sat_hit = w_ovf;
        if (!w_ovf)         w_result = w_sum[PW-1:0];
        else if (w_sum[PW]) w_result = PSUM_MIN;
        else                w_result = PSUM_MAX;
      end
      OP_LOAD: w_result = r_s3_data;
      default: w_result = '0;
    endcase
  end

  // NOTE: the psum spad is small and must read back as zero after reset, so it is
  // built from resettable flops rather than a RAM macro.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 2**PSUM_ADDR_BITWIDTH; i++) r_psum_mem[i] <= '0;
    end else if (r_s3_valid) begin
      r_psum_mem[r_s3_a] <= w_result;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_sat <= 1'b0;
    else       r_sat <= (r_sat & ~i_clr_sat) | (r_s3_valid & w_sat_hit);
  end

  assign w_push = r_s3_valid & r_s3_out;
  assign w_pop  = o_psum_valid & i_psum_ready;

  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= w_result;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Every in-flight i_out op holds a reserved FIFO slot, so accepted ops never stall.
  assign w_inflight = CNT_W'(r_s1_valid & r_s1_out) + CNT_W'(r_s2_valid & r_s2_out)
                    + CNT_W'(r_s3_valid & r_s3_out);
  assign o_issue_ready = (r_count + w_inflight) < CNT_W'(OUT_FIFO_DEPTH);

  assign o_psum_valid = (r_count != '0);
  assign o_psum_data  = r_fifo_mem[r_rd_ptr];
  assign o_sat        = r_sat;

endmodule

// File: tb/tb_pe_datapath_v2.sv
// Scoreboard bench for pe_datapath_v2: directed scenarios plus random traffic
// compared against an op-level arithmetic model.
module tb_pe_datapath_v2;

  localparam int DW  = 8;
  localparam int PW  = 20;
  localparam int IA  = 4;
  localparam int WA  = 7;
  localparam int PA  = 3;
  localparam int DEP = 4;

  localparam logic [1:0] OP_MAC  = 2'b00;
  localparam logic [1:0] OP_ACC  = 2'b01;
  localparam logic [1:0] OP_CLR  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  localparam longint PMAX = (longint'(1) << (PW-1)) - 1;
  localparam longint PMIN = -(longint'(1) << (PW-1));

  logic          clk;
  logic          i_rst;
  logic          i_ifmap_we, i_wght_we;
  logic [IA-1:0] i_ifmap_wa, i_ifmap_ra;
  logic [WA-1:0] i_wght_wa, i_wght_ra;
  logic [DW-1:0] i_ifmap_data, i_wght_data;
  logic          i_issue, o_issue_ready;
  logic [1:0]    i_op;
  logic          i_out;
  logic [PA-1:0] i_psum_a;
  logic [PW-1:0] i_psum_data, o_psum_data;
  logic          o_psum_valid, i_psum_ready;
  logic          o_sat, i_clr_sat;

  pe_datapath_v2 #(
    .DATA_BITWIDTH(DW), .PSUM_BITWIDTH(PW), .IFMAP_ADDR_BITWIDTH(IA),
    .WGHT_ADDR_BITWIDTH(WA), .PSUM_ADDR_BITWIDTH(PA), .OUT_FIFO_DEPTH(DEP)
  ) dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_ifmap_we(i_ifmap_we), .i_ifmap_wa(i_ifmap_wa), .i_ifmap_data(i_ifmap_data),
    .i_wght_we(i_wght_we), .i_wght_wa(i_wght_wa), .i_wght_data(i_wght_data),
    .i_issue(i_issue), .o_issue_ready(o_issue_ready), .i_op(i_op), .i_out(i_out),
    .i_ifmap_ra(i_ifmap_ra), .i_wght_ra(i_wght_ra), .i_psum_a(i_psum_a),
    .i_psum_data(i_psum_data), .o_psum_data(o_psum_data), .o_psum_valid(o_psum_valid),
    .i_psum_ready(i_psum_ready), .o_sat(o_sat), .i_clr_sat(i_clr_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     total = 0;
  int     bad   = 0;
  longint m_psum [2**PA];
  int     m_ifmap [2**IA];
  int     m_wght [2**WA];
  longint exp_q [$];
  int     outstanding = 0;
  bit     m_sat = 1'b0;
  bit     last_acc;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Op-level reference: apply the op to the model psum array in issue order.
  task automatic model_issue();
    longint sum, res;
    bit hit;
    sum = 0; res = 0; hit = 1'b0;
    case (i_op)
      OP_MAC:  sum = m_psum[i_psum_a] + longint'(m_ifmap[i_ifmap_ra]) * longint'(m_wght[i_wght_ra]);
      OP_ACC:  sum = m_psum[i_psum_a] + longint'($signed(i_psum_data));
      OP_CLR:  res = 0;
      default: res = longint'($signed(i_psum_data));
    endcase
    if (i_op == OP_MAC || i_op == OP_ACC) begin
      if (sum > PMAX)      begin res = PMAX; hit = 1'b1; end
      else if (sum < PMIN) begin res = PMIN; hit = 1'b1; end
      else                 res = sum;
    end
    m_psum[i_psum_a] = res;
    if (hit) m_sat = 1'b1;
    if (i_out) begin
      exp_q.push_back(res);
      outstanding++;
    end
  endtask

  // One clock: inputs were driven at the previous negedge.
  task automatic step();
    #2;
    check("issue_ready", o_issue_ready, (outstanding < DEP) ? 1 : 0);
    #2;
    last_acc = 1'b0;
    if (i_issue && o_issue_ready && !i_rst) begin
      model_issue();
      last_acc = 1'b1;
    end
    if (i_ifmap_we) m_ifmap[i_ifmap_wa] = int'($signed(i_ifmap_data));
    if (i_wght_we)  m_wght[i_wght_wa]   = int'($signed(i_wght_data));
    @(negedge clk);
  endtask

  task automatic do_op(input logic [1:0] op, input int a, input longint data,
                       input bit out, input int ra, input int wa);
    i_op = op; i_psum_a = PA'(a); i_psum_data = PW'(data); i_out = out;
    i_ifmap_ra = IA'(ra); i_wght_ra = WA'(wa); i_issue = 1'b1;
    step();
    i_issue = 1'b0; i_out = 1'b0;
  endtask

  task automatic idle();
    i_issue = 1'b0; i_out = 1'b0; i_ifmap_we = 1'b0; i_wght_we = 1'b0; i_clr_sat = 1'b0;
  endtask

  task automatic drain();
    idle();
    i_psum_ready = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() > 0; k++) step();
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (4) step();
    check("drained_empty", o_psum_valid, 0);
  endtask

  // Monitor: pops happen at the next posedge when valid && ready.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (!i_rst && o_psum_valid && i_psum_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", $signed(o_psum_data), 64'sd999999999);
        end else begin
          check("out_data", $signed(o_psum_data), exp_q.pop_front());
          outstanding--;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    i_rst = 1'b1; idle();
    i_ifmap_wa = '0; i_ifmap_data = '0; i_wght_wa = '0; i_wght_data = '0;
    i_op = OP_MAC; i_psum_a = '0; i_psum_data = '0; i_ifmap_ra = '0; i_wght_ra = '0;
    i_psum_ready = 1'b1;
    for (int i = 0; i < 2**PA; i++) m_psum[i] = 0;
    repeat (2) @(negedge clk);
    check("rst_valid", o_psum_valid, 0);
    check("rst_ready", o_issue_ready, 1);
    check("rst_sat", o_sat, 0);
    i_rst = 1'b0;
    @(negedge clk);

    // Fill both spads so every later read is defined.
    for (int k = 0; k < 2**WA; k++) begin
      i_wght_we = 1'b1; i_wght_wa = WA'(k); i_wght_data = DW'($urandom);
      i_ifmap_we = (k < 2**IA); i_ifmap_wa = IA'(k); i_ifmap_data = DW'($urandom);
      step();
    end
    idle();

    // LOAD then MAC: 10 + 3*(-4) = -2, three cycles after issue.
    i_ifmap_we = 1'b1; i_ifmap_wa = 0; i_ifmap_data = 8'd3;
    i_wght_we = 1'b1; i_wght_wa = 0; i_wght_data = 8'hFC;
    step(); idle();
    do_op(OP_LOAD, 2, 10, 0, 0, 0);
    do_op(OP_MAC, 2, 0, 1, 0, 0);
    step(); step();
    check("lat_early_valid", o_psum_valid, 0);
    step();
    check("lat_valid", o_psum_valid, 1);
    check("lat_data", $signed(o_psum_data), -2);
    drain();

    // CLR then 8 back-to-back MACs of 5*7.
    i_ifmap_we = 1'b1; i_ifmap_wa = 1; i_ifmap_data = 8'd5;
    i_wght_we = 1'b1; i_wght_wa = 1; i_wght_data = 8'd7;
    step(); idle();
    do_op(OP_CLR, 1, 0, 0, 0, 0);
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      do_op(OP_MAC, 1, 0, (k == 7), 1, 1);
      if (last_acc) acc++;
    end
    check("b2b_accepted", acc, 8);
    repeat (3) step();
    check("b2b_data", $signed(o_psum_data), 280);
    drain();

    // Positive saturation and sticky flag.
    do_op(OP_LOAD, 0, 524188, 0, 0, 0);
    do_op(OP_ACC, 0, 500, 1, 0, 0);
    repeat (3) step();
    check("sat_data", $signed(o_psum_data), 524287);
    drain();
    check("sat_set", o_sat, 1);
    i_clr_sat = 1'b1; step(); i_clr_sat = 1'b0;
    check("sat_cleared", o_sat, 0);
    // Saturation event coinciding with a clear leaves the flag set.
    do_op(OP_ACC, 0, 500, 0, 0, 0);
    step(); step();
    i_clr_sat = 1'b1; step(); i_clr_sat = 1'b0;
    check("sat_vs_clr", o_sat, 1);
    i_clr_sat = 1'b1; step(); i_clr_sat = 1'b0;
    check("sat_cleared2", o_sat, 0);
    m_sat = 1'b0;

    // Backpressure: only DEP i_out ops may be outstanding.
    i_psum_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      i_op = OP_LOAD; i_psum_a = PA'(k); i_psum_data = PW'(1000 * k + 7);
      i_out = 1'b1; i_issue = 1'b1;
      step();
      if (last_acc) acc++;
    end
    idle();
    check("bp_accepted", acc, DEP);
    check("bp_ready_low", o_issue_ready, 0);
    drain();

    // Reset with a MAC in flight: no output, psum spad cleared, spads kept.
    do_op(OP_MAC, 5, 0, 1, 0, 0);
    step();
    i_rst = 1'b1;
    exp_q.delete();
    outstanding = 0;
    for (int i = 0; i < 2**PA; i++) m_psum[i] = 0;
    #1;
    check("midrst_valid", o_psum_valid, 0);
    check("midrst_ready", o_issue_ready, 1);
    #1;
    @(negedge clk);
    step();
    i_rst = 1'b0;
    repeat (5) step();
    check("postrst_valid", o_psum_valid, 0);
    for (int a = 0; a < 2**PA; a++) do_op(OP_ACC, a, 0, 1, 0, 0);
    do_op(OP_MAC, 6, 0, 1, 0, 0);
    drain();

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      i_psum_ready = ($urandom_range(3) != 0);
      i_ifmap_we = 1'($urandom_range(1)); i_ifmap_wa = IA'($urandom); i_ifmap_data = DW'($urandom);
      i_wght_we = 1'($urandom_range(1)); i_wght_wa = WA'($urandom); i_wght_data = DW'($urandom);
      i_issue = ($urandom_range(9) < 6);
      i_op = 2'($urandom); i_out = 1'($urandom_range(1));
      i_ifmap_ra = IA'($urandom); i_wght_ra = WA'($urandom); i_psum_a = PA'($urandom);
      i_psum_data = ($urandom_range(3) == 0) ? PW'($urandom) : PW'($urandom_range(2000) - 1000);
      step();
    end
    drain();
    check("sat_random", o_sat, m_sat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
